dog_extrema_detect: RTL
=======================

Name: dog_extrema_detect

Overview:
- Consumes the three-layer DoG stream (diff0/diff1/diff2, signed 8-bit, qualified by out_en) produced by the Gaussian/DoG pyramid stage.
- Buffers two lines per layer to form 3x3x3 neighbourhoods, and flags each diff1 pixel that is a strict local maximum or minimum over its 26 neighbours and passes a contrast threshold.
- Emits keypoint candidates with image coordinates to the downstream keypoint/descriptor stage.
- Runs once per octave; frame geometry is loaded per frame so the same instance serves the full-size and downsampled images.

Parameters:
MAX_W, 640, maximum line width; line buffer depth per layer.
CW, 11, coordinate / size port width.
THRESH, 3, contrast threshold; unsigned magnitude compared against the centre value.

Ports:
clk  in  1  clock; all logic on rising edge.
rst  in  1  synchronous, active-low reset.
frame_start  in  1  one-cycle pulse; loads line_w/line_h and restarts the coordinate counters.
line_w  in  CW  frame width in pixels, sampled on frame_start; range 3..MAX_W.
line_h  in  CW  frame height in pixels, sampled on frame_start.
in_en  in  1  sample valid; connected to the DoG out_en.
diff0  in  8  signed DoG layer 0.
diff1  in  8  signed DoG layer 1; the layer tested for extrema.
diff2  in  8  signed DoG layer 2.
kp_valid  out  1  one-cycle keypoint strobe.
kp_x  out  CW  keypoint column.
kp_y  out  CW  keypoint row.
kp_type  out  1  1 = maximum, 0 = minimum.
kp_val  out  8  signed diff1 value at the keypoint.
frame_done  out  1  one-cycle pulse when frame processing is complete.
busy  out  1  high from frame_start until frame_done.

Behaviour:
- Reset (rst=0 at a clock edge):
  - All outputs go to 0; counters, pipeline valid bits and the FSM are cleared.
  - Line buffer contents are not cleared.
  - Any keypoint in flight is dropped.
- FSM states:
  - IDLE -> RUN on frame_start.
  - RUN -> FLUSH after the sample at (line_w-1, line_h-1) is accepted.
  - FLUSH -> IDLE after 3 cycles. frame_done pulses on the FLUSH exit cycle, i.e. 3 cycles after the last accept, after any final kp_valid.
  - frame_start in any state returns to RUN with counters at (0,0) and pipeline valid bits cleared. This aborts the current frame; no frame_done is issued for the aborted frame.
- Acceptance and coordinates:
  - A sample is accepted when in_en=1 in RUN.
  - If frame_start and in_en are both high in the same cycle, that sample is pixel (0,0) of the new frame.
  - in_en in IDLE or FLUSH is ignored.
  - Column counter c wraps at line_w-1 and increments row r.
  - Gaps in in_en stall the counters and line buffers only; stages already in flight continue to completion.
- Buffering:
  - Per layer: 2 line buffers (depth MAX_W, read/write at column c) plus a 3x3 shift window that advances on accept.
- Evaluation:
  - Accepting the sample at (c,r) with c>=2 and r>=2 completes the window centred at (c-1, r-1). Border pixels are therefore never reported.
  - Stage 1 (edge of accept): window registers update.
  - Stage 2 (next edge): 26 signed comparisons are performed and the outputs are registered.
  - kp_valid is high exactly in the cycle 2 clocks after the accepting edge. kp_x=c-1, kp_y=r-1.
- Extremum rule, with V = centre diff1 value, as signed 8-bit compares:
  - Maximum: V strictly greater than all 8 diff1 neighbours and all 9 diff0 and 9 diff2 window values, and V > THRESH.
  - Minimum: V strictly less than all 26, and V < -THRESH.
  - Any tie is not an extremum.
  - Max and min cannot both hold.
- Sizes: line_w<3 or line_h<3 produces no kp_valid; frame_done is still issued after line_w*line_h accepted samples.

Test Plan:
1. Reset: hold rst=0 for 2 cycles with in_en=1 -> all outputs 0, busy=0, no kp_valid.
2. Single maximum: 5x5 frame, all layers 0 except diff1(2,2)=20, in_en continuous -> exactly one kp_valid, 2 cycles after sample (3,3); kp_x=2, kp_y=2, kp_type=1, kp_val=20. frame_done 3 cycles after sample (4,4).
3. Tie: same frame as test 2 but diff0(1,1)=20 -> no kp_valid. Change diff0(1,1) to 19 -> keypoint is reported.
4. Minimum and threshold: diff1(2,2)=-20 -> kp_type=0, kp_val=-20. With diff1(2,2)=-3 (THRESH=3) -> no kp_valid. With -4 -> keypoint reported.
5. Stalls and abort: test-2 frame with in_en toggling 1,0,0,1 -> identical keypoint, still 2 cycles after its accepting edge. Issue frame_start at pixel (1,3) mid-frame -> no frame_done for that frame; a following clean 5x5 frame reports correctly.
6. Octave switch: 8x6 frame, then frame_start with line_w=4, line_h=3 and maxima at (1,1) and (2,1) that are distinct -> coordinates wrap at 4. Only the larger of two adjacent equal-height candidates is reported; if they are equal, neither is.

Source files
------------

// File: rtl/dog_extrema_detect_if.sv
// DoG sample stream into the extrema detector and the
// keypoint candidate bus out of it.
interface dog_extrema_detect_if #(
    parameter int CW = 11
) ();
    logic              in_en;
    logic signed [7:0] diff0;
    logic signed [7:0] diff1;
    logic signed [7:0] diff2;
    logic              kp_valid;
    logic [CW-1:0]     kp_x;
    logic [CW-1:0]     kp_y;
    logic              kp_type;
    logic signed [7:0] kp_val;

    modport master (
        output in_en, diff0, diff1, diff2,
        input  kp_valid, kp_x, kp_y, kp_type, kp_val
    );

    modport slave (
        input  in_en, diff0, diff1, diff2,
        output kp_valid, kp_x, kp_y, kp_type, kp_val
    );
endinterface

// File: rtl/dog_extrema_detect.sv
// 3x3x3 DoG local extremum detector: two line buffers per
// layer, a shift window, and a registered 26-way compare.
module dog_extrema_detect #(
    parameter int MAX_W  = 640,
    parameter int CW     = 11,
    parameter int THRESH = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          frame_start,
    input  logic [CW-1:0] line_w,
    input  logic [CW-1:0] line_h,
    dog_extrema_detect_if.slave io,
    output logic          frame_done,
    output logic          busy
);
    localparam int AW = $clog2(MAX_W);
    localparam logic [CW-1:0] TWO = CW'(2);
    localparam logic signed [7:0] THR = 8'(THRESH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } state_t;

    state_t        state;
    logic [CW-1:0] w_reg;
    logic [CW-1:0] h_reg;
    logic [CW-1:0] c;
    logic [CW-1:0] r;
    logic [1:0]    fcnt;

    logic          accept;
    logic          row_end;
    logic          last;
    logic [CW-1:0] col;
    logic [CW-1:0] row;
    logic [CW-1:0] wid;
    logic [CW-1:0] hgt;
    logic [AW-1:0] a;
    logic [23:0]   pix;
    logic [23:0]   rd0;
    logic [23:0]   rd1;

    logic [23:0]   lb0 [MAX_W];
    logic [23:0]   lb1 [MAX_W];
    logic [23:0]   win [3][3];

    logic          v1;
    logic [CW-1:0] cx;
    logic [CW-1:0] cy;

    logic signed [7:0] ctr;
    logic signed [7:0] nb;
    logic              is_max;
    logic              is_min;

    // frame_start makes the same-cycle sample pixel (0,0)
    assign col     = frame_start ? '0 : c;
    assign row     = frame_start ? '0 : r;
    assign wid     = frame_start ? line_w : w_reg;
    assign hgt     = frame_start ? line_h : h_reg;
    assign accept  = io.in_en &&
                     (frame_start || state == RUN);
    assign row_end = col == wid - 1'b1;
    assign last    = row_end && row == hgt - 1'b1;
    assign a       = col[AW-1:0];
    assign pix     = {io.diff2, io.diff1, io.diff0};
    assign rd0     = lb0[a];
    assign rd1     = lb1[a];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            w_reg      <= '0;
            h_reg      <= '0;
            c          <= '0;
            r          <= '0;
            fcnt       <= '0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (frame_start) begin
                state <= RUN;
                w_reg <= line_w;
                h_reg <= line_h;
                c     <= '0;
                r     <= '0;
                busy  <= 1'b1;
            end
            if (accept) begin
                if (last) begin
                    state <= FLUSH;
                    fcnt  <= '0;
                end else if (row_end) begin
                    c <= '0;
                    r <= row + 1'b1;
                end else begin
                    c <= col + 1'b1;
                end
            end else if (state == FLUSH && !frame_start) begin
                if (fcnt == 2'd2) begin
                    state      <= IDLE;
                    frame_done <= 1'b1;
                    busy       <= 1'b0;
                end else begin
                    fcnt <= fcnt + 1'b1;
                end
            end
        end
    end

    // row r-1 lives in lb0, row r-2 in lb1; column 2 of win is newest
    always_ff @(posedge clk) begin
        if (accept) begin
            lb0[a] <= pix;
            lb1[a] <= rd0;
            for (int i = 0; i < 3; i++) begin
                win[i][0] <= win[i][1];
                win[i][1] <= win[i][2];
            end
            win[0][2] <= rd1;
            win[1][2] <= rd0;
            win[2][2] <= pix;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            v1 <= 1'b0;
            cx <= '0;
            cy <= '0;
        end else begin
            v1 <= accept && col >= TWO && row >= TWO;
            cx <= col - 1'b1;
            cy <= row - 1'b1;
        end
    end

    always_comb begin
        nb     = '0;
        ctr    = $signed(win[1][1][15:8]);
        is_max = ctr > THR;
        is_min = ctr < -THR;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                for (int l = 0; l < 3; l++) begin
                    if (!(i == 1 && j == 1 && l == 1)) begin
                        nb     = $signed(win[i][j][8*l +: 8]);
                        is_max = is_max && (ctr > nb);
                        is_min = is_min && (ctr < nb);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            io.kp_valid <= 1'b0;
            io.kp_x     <= '0;
            io.kp_y     <= '0;
            io.kp_type  <= 1'b0;
            io.kp_val   <= '0;
        end else begin
            io.kp_valid <= v1 && !frame_start &&
                           (is_max || is_min);
            if (v1) begin
                io.kp_x    <= cx;
                io.kp_y    <= cy;
                io.kp_type <= is_max;
                io.kp_val  <= ctr;
            end
        end
    end
endmodule
